// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Sequencer states: normal operation or multi-cycle soft reset.
    typedef enum logic {
        RUN     = 1'b0,
        RST_SEQ = 1'b1
    } state_t;

    // Stage indices for the default 3-stage core.
    localparam int STG_FETCH = 0;
    localparam int STG_DEC   = 1;
    localparam int STG_EXE   = 2;

    // Default sequencing parameters.
    localparam int DEF_NSTAGE         = 3;
    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_prio_enc.sv
// Highest-set-bit priority encoder for stall requests.
// The most downstream requesting stage k gets a bubble; every stage
// upstream of k holds. Stages downstream of k are left running.
module stall_prio_enc #(
    parameter int N = 3
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [N-1:0] o_stall_mask,
    output logic [N-1:0] o_flush_mask
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] w_idx;

    // Scan upward so the highest requesting index wins.
    always_comb begin
        w_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (i_req[j]) w_idx = IDX_W'(j);
        end
    end

    assign o_valid      = |i_req;
    // One-hot at k; everything strictly below k is (one-hot - 1).
    assign o_flush_mask = o_valid ? (N'(1) << w_idx) : '0;
    assign o_stall_mask = o_valid ? (o_flush_mask - N'(1)) : '0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: stall arbitration, deferred interrupt
// flush with acknowledge, multi-cycle soft reset and a stall watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE         = DEF_NSTAGE,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NSTAGE-1:0] i_stall_req,
    input  logic              i_int_req,
    input  logic              i_rst_req,
    output logic [NSTAGE-1:0] o_stage_stall,
    output logic [NSTAGE-1:0] o_stage_flush,
    output logic              o_pc_stall,
    output logic              o_group_rst,
    output logic              o_int_ack,
    output logic              o_stall_timeout
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [RC_W-1:0]   w_rst_cnt_nxt;
    logic              r_int_pend;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_stall_timeout;

    logic              w_stall_any;
    logic [NSTAGE-1:0] w_stall_mask;
    logic [NSTAGE-1:0] w_flush_mask;
    logic              w_in_rst;
    logic              w_int_eff;

    stall_prio_enc #(.N(NSTAGE)) u_enc (
        .i_req        (i_stall_req),
        .o_valid      (w_stall_any),
        .o_stall_mask (w_stall_mask),
        .o_flush_mask (w_flush_mask)
    );

    // A fresh restart request acts in the same cycle, before the FSM moves.
    assign w_in_rst  = i_rst_req || (r_state == RST_SEQ);
    assign w_int_eff = i_int_req || r_int_pend;

    // FSM state and soft-reset down-counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RUN;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
        end
    end

    // Next state plus all hold/bubble/clear outputs, in priority order.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        o_stage_stall = '0;
        o_stage_flush = '0;
        o_pc_stall    = 1'b0;
        o_group_rst   = 1'b0;
        o_int_ack     = 1'b0;

        if (i_rst_req) begin
            w_state_nxt   = RST_SEQ;
            w_rst_cnt_nxt = RC_LOAD;
        end else if (r_state == RST_SEQ) begin
            if (r_rst_cnt == '0) w_state_nxt = RUN;
            else                 w_rst_cnt_nxt = r_rst_cnt - 1'b1;
        end

        if (w_in_rst) begin
            o_stage_flush = '1;
            o_group_rst   = 1'b1;
        end else if (w_stall_any) begin
            o_stage_stall = w_stall_mask;
            o_stage_flush = w_flush_mask;
            o_pc_stall    = 1'b1;
        end else if (w_int_eff) begin
            o_stage_flush = '1;
            o_int_ack     = 1'b1;
        end
    end

    // Pending interrupt: captured in RUN, dropped on ack or any reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_in_rst) begin
            r_int_pend <= 1'b0;
        end else if (o_int_ack) begin
            r_int_pend <= 1'b0;
        end else if (i_int_req) begin
            r_int_pend <= 1'b1;
        end
    end

    // Watchdog: count consecutive stalled RUN cycles, flag is sticky.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (w_in_rst || !w_stall_any) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (i_rst_req) begin
                r_stall_timeout <= 1'b0;
            end else if (!w_in_rst && w_stall_any && r_stall_cnt == CNT_LAST) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign o_stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (NSTAGE=3,
// RST_CYCLES=4, TIMEOUT_CYCLES=16). Inputs change on the falling edge,
// outputs are compared 1 ns later.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] stall_req;
    logic       int_req;
    logic       rst_req;
    logic [2:0] stage_stall;
    logic [2:0] stage_flush;
    logic       pc_stall;
    logic       group_rst;
    logic       int_ack;
    logic       stall_timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] sr;
        logic       ir;
        logic       rr;
        logic [9:0] exp;   // {stall[2:0], flush[2:0], pc, grst, ack, timeout}
    } vec_t;

    vec_t vecs[$];

    pipe_hazard_ctrl #(
        .NSTAGE(3), .RST_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_W(8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall_req    (stall_req),
        .i_int_req      (int_req),
        .i_rst_req      (rst_req),
        .o_stage_stall  (stage_stall),
        .o_stage_flush  (stage_flush),
        .o_pc_stall     (pc_stall),
        .o_group_rst    (group_rst),
        .o_int_ack      (int_ack),
        .o_stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {stage_stall, stage_flush, pc_stall, group_rst, int_ack, stall_timeout};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (stall,flush,pc,grst,ack,to)", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] sr, input logic ir, input logic rr,
                         input logic [9:0] exp, input string nm);
        @(negedge clk);
        stall_req = sr;
        int_req   = ir;
        rst_req   = rr;
        #1;
        chk(nm, outs(), exp);
    endtask

    task automatic add(input logic [2:0] sr, input logic ir, input logic rr,
                       input logic [2:0] st, input logic [2:0] fl,
                       input logic pc, input logic gr, input logic ak, input logic to);
        vec_t v;
        v.sr  = sr;
        v.ir  = ir;
        v.rr  = rr;
        v.exp = {st, fl, pc, gr, ak, to};
        vecs.push_back(v);
    endtask

    // Per-cycle invariants.
    always @(posedge clk) begin
        if (!rst) begin
            if ((stage_stall & stage_flush) != 3'b000) begin
                errors++;
                $display("FAIL inv_stall_flush: stall=%b flush=%b overlap required 000",
                         stage_stall, stage_flush);
            end
            if (int_ack && (stall_req != 3'b000 || dut.r_state != RUN)) begin
                errors++;
                $display("FAIL inv_ack: ack=1 with stall_req=%b state=%0d, required stall_req=000 in RUN",
                         stall_req, dut.r_state);
            end
        end
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; stall_req = '0; int_req = 1'b0; rst_req = 1'b0;

        // Fetch stall, 3 cycles, then idle
        for (int i = 0; i < 3; i++) add(3'b001, 0, 0, 3'b000, 3'b001, 1, 0, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        // Downstream priority and masking
        add(3'b101, 0, 0, 3'b011, 3'b100, 1, 0, 0, 0);
        add(3'b110, 0, 0, 3'b011, 3'b100, 1, 0, 0, 0);
        add(3'b010, 0, 0, 3'b001, 3'b010, 1, 0, 0, 0);
        // Interrupt pulse deferred behind a 5-cycle memory stall
        add(3'b100, 1, 0, 3'b011, 3'b100, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(3'b100, 0, 0, 3'b011, 3'b100, 1, 0, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b111, 0, 0, 1, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        // Interrupt with no stall acks immediately
        add(3'b000, 1, 0, 3'b000, 3'b111, 0, 0, 1, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        // Soft-reset pulse with concurrent interrupt: 5 flush cycles, no ack
        add(3'b000, 1, 1, 3'b000, 3'b111, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(3'b000, 0, 0, 3'b000, 3'b111, 0, 1, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        // Soft reset retriggered mid-sequence; interrupt during it is ignored
        add(3'b000, 0, 1, 3'b000, 3'b111, 0, 1, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b111, 0, 1, 0, 0);
        add(3'b000, 0, 1, 3'b000, 3'b111, 0, 1, 0, 0);
        add(3'b000, 1, 0, 3'b000, 3'b111, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(3'b000, 0, 0, 3'b000, 3'b111, 0, 1, 0, 0);
        add(3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);

        // Reset state with zero inputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", outs(), 10'b0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i].sr, vecs[i].ir, vecs[i].rr, vecs[i].exp, $sformatf("vec%0d", i));

        // Watchdog: 20 stalled cycles, flag visible from the 17th
        for (int i = 0; i < 20; i++)
            apply(3'b010, 0, 0, {3'b001, 3'b010, 1'b1, 1'b0, 1'b0, (i >= 16)}, $sformatf("wdog%0d", i));
        apply(3'b000, 0, 0, 10'b0000000001, "wdog_sticky0");
        apply(3'b000, 0, 0, 10'b0000000001, "wdog_sticky1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wdog_port_rst", outs(), 10'b0);

        // Soft reset during a stall with a pending interrupt and timeout set
        for (int i = 0; i < 18; i++)
            apply(3'b010, (i == 0), 0, {3'b001, 3'b010, 1'b1, 1'b0, 1'b0, (i >= 16)}, $sformatf("rmid_stall%0d", i));
        apply(3'b010, 0, 1, {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1}, "rmid_override");
        for (int i = 0; i < 4; i++)
            apply(3'b010, 0, 0, {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0}, $sformatf("rmid_seq%0d", i));
        apply(3'b000, 0, 0, 10'b0, "rmid_idle_noack");
        apply(3'b000, 0, 0, 10'b0, "rmid_idle2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline stall/flush sequencer for the CPU core; successor to the fixed 3-stage timing controller.
- Generalises to NSTAGE stages, each with its own stall request, and keeps state across cycles.
- Adds a pending-interrupt latch with an acknowledge pulse, a multi-cycle soft-reset sequence, and a stall watchdog.
- Sits beside the PC, fetch, decode and execute stages; drives their hold/bubble inputs and the register-group clear.

Parameters:
- NSTAGE, 3, number of pipeline stages; index 0 = fetch, NSTAGE-1 = last (execute/memory) stage.
- RST_CYCLES, 4, number of cycles the soft-reset sequence holds all flushes and the register-group clear; legal range ≥1.
- TIMEOUT_CYCLES, 255, consecutive stalled cycles before stall_timeout sets; legal range ≥1.
- CNT_W, 8, width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stall_req  in  NSTAGE  bit k: stage k waiting on cache/memory.
- int_req  in  1  interrupt controller flush request (level).
- rst_req  in  1  software/debug CPU restart request (level or pulse).
- stage_stall  out  NSTAGE  bit k: stage k holds its output register.
- stage_flush  out  NSTAGE  bit k: stage k loads a bubble.
- pc_stall  out  1  PC holds.
- group_rst  out  1  register-group clear.
- int_ack  out  1  one-cycle pulse when the interrupt flush is issued.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- On rst, all state clears:
  - state=RUN, int_pend=0, stall_cnt=0, rst_cnt=0, stall_timeout=0.
  - All combinational outputs evaluate to 0 with zero inputs.
- FSM has two states, RUN and RST_SEQ.
- rst_req=1 in any state: enter RST_SEQ next cycle with rst_cnt=RST_CYCLES-1.
  - rst_req also acts combinationally in the same cycle: stage_flush=all 1s, group_rst=1, all stalls 0.
- RST_SEQ:
  - Outputs: stage_flush=all 1s, group_rst=1, stage_stall=0, pc_stall=0, int_ack=0.
  - Each cycle decrements rst_cnt; at 0 (and rst_req=0) return to RUN.
  - A new rst_req reloads rst_cnt.
  - int_pend clears on entry.
  - Net effect: rst_req seen in cycle 0 gives exactly RST_CYCLES+1 cycles of flush.
- RUN, stall arbitration:
  - Let k = highest index with stall_req[k]=1 (downstream has priority).
  - stage_stall[j]=1 for all j<k.
  - stage_flush[k]=1.
  - Stages above k run normally.
  - pc_stall=1.
  - Lower-index stall requests are masked.
- RUN, interrupt:
  - int_req sets int_pend (registered).
  - Flush fires in the first cycle with int_eff=(int_req|int_pend)=1 and stall_req==0:
    - stage_flush=all 1s, pc_stall=0, group_rst=0, int_ack=1.
    - int_pend clears next cycle.
  - If any stall_req is active, the interrupt waits. It never aborts an in-flight memory access.
  - int_req held high after ack re-sets int_pend; the interrupt controller must drop int_req on int_ack.
- Priority: rst (port) > rst_req/RST_SEQ > stall arbitration > interrupt > idle (all 0).
- Watchdog:
  - stall_cnt increments (saturating at all 1s) each RUN cycle with stall_req!=0.
  - stall_cnt resets to 0 on a cycle with no stall_req, or in RST_SEQ.
  - When stall_cnt==TIMEOUT_CYCLES-1 and a stall is still present, stall_timeout sets next cycle.
  - stall_timeout clears only on rst or rst_req.
- Latency: stall/flush outputs are combinational from inputs plus registered state (0 cycles). int_pend, counters and FSM update on the clk edge.
- Invariants (checked by bench assertions):
  - stage_stall & stage_flush == 0 in every cycle.
  - int_ack implies stall_req==0 and state==RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, RST_SEQ};
  - stage index constants (STG_FETCH=0, STG_DEC=1, STG_EXE=2);
  - default RST_CYCLES and TIMEOUT_CYCLES.
- One natural sub-module: stall_prio_enc, a parametrised highest-set-bit priority encoder with a valid flag. It returns k and generates the stall/flush masks.
- The FSM, counters and int latch stay in the top module.

Test Plan (NSTAGE=3, RST_CYCLES=4, TIMEOUT_CYCLES=16):
- Fetch stall: stall_req=001 for 3 cycles -> stage_flush=001, stage_stall=000, pc_stall=1 each cycle; then all 0.
- Memory stall masking: stall_req=101 -> stage_stall=011, stage_flush=100, pc_stall=1. Fetch request masked.
- Interrupt deferral:
  - int_req pulses 1 cycle while stall_req=100 for 5 cycles -> no int_ack during stall.
  - Cycle after stall_req→000: stage_flush=111, pc_stall=0, int_ack=1 for exactly 1 cycle.
- Soft reset: rst_req 1-cycle pulse in cycle 0 -> group_rst=1 and stage_flush=111 in cycles 0–4, back to idle in cycle 5. A concurrent int_req is discarded (int_pend cleared), no int_ack.
- Reset mid-operation: rst_req asserted during an active stall_req=010 plus pending interrupt -> reset outputs override the stall immediately; stall_timeout and int_pend cleared.
- Watchdog: stall_req=010 held 20 cycles -> stall_timeout rises after cycle 16 and stays set after stall_req drops; cleared by rst=1.
